sram_test_sequencer: RTL
========================

// Module: sram_test_sequencer
// PURPOSE
//  Drives an SRAM controller through write-all / read-all passes over the full address space,
//  one data pattern per pass. Feeds each read word and its expected value to result_checker
//  (read_data / expected_data / enable) and reports progress.
//  Sits between board top-level start/status and the SRAM controller plus checker in sram_test.
// PARAMETERS
//  ADDR_BITS  20  SRAM word-address width; the sequencer covers addresses 0 .. 2^ADDR_BITS-1
//  DATA_BITS  16  SRAM data width; matches result_checker DATA_BITS
// PORTS
//  clk                input   1          system clock
//  reset_n            input   1          synchronous reset, active low
//  start              input   1          pulse: begin a run; ignored unless state is IDLE or DONE
//  loop               input   1          1: after pattern 3, wrap to pattern 0; 0: stop in DONE
//  stop               input   1          level: finish the current pass, then go to DONE
//  mem_req            output  1          request valid; held until accepted
//  mem_write          output  1          1 = write, 0 = read; valid while mem_req = 1
//  mem_addr           output  ADDR_BITS  request address
//  mem_wdata          output  DATA_BITS  write data
//  mem_ready          input   1          request accepted when mem_req & mem_ready
//  mem_rvalid         input   1          read data valid, one cycle
//  mem_rdata          input   DATA_BITS  read data
//  chk_enable         output  1          one-cycle compare strobe to the checker
//  chk_read_data      output  DATA_BITS  registered mem_rdata
//  chk_expected_data  output  DATA_BITS  pattern value for the same address
//  busy               output  1          state is neither IDLE nor DONE
//  done               output  1          state is DONE
//  pattern            output  2          current pattern index
//  iteration          output  16         count of completed 4-pattern loops; wraps
// BEHAVIOUR
//  - Reset (reset_n = 0 at a clk edge), applies mid-operation as well:
//    state = IDLE; all outputs = 0; any in-flight request is abandoned.
//  - States: IDLE, WR, RD, RD_WAIT, CHK, NEXT, DONE.
//  - IDLE/DONE --start--> WR, with addr = 0, pattern = 0, iteration = 0.
//  - WR: mem_req = 1, mem_write = 1, mem_wdata = P(pattern, addr).
//    On accept: at the last address, go to RD with addr = 0; otherwise addr++.
//  - RD: mem_req = 1, mem_write = 0. On accept -> RD_WAIT. Only one read is outstanding.
//  - RD_WAIT: on mem_rvalid, capture mem_rdata into chk_read_data and P(pattern, addr) into
//    chk_expected_data -> CHK. mem_rvalid in any other state is ignored.
//  - CHK: chk_enable = 1 for exactly this cycle.
//    At the last address -> NEXT; otherwise addr++ -> RD.
//  - NEXT (1 cycle):
//    - If stop = 1, or (pattern = 3 and loop = 0) -> DONE.
//    - Otherwise pattern++ (3 wraps to 0). On that wrap, iteration++. Then addr = 0 -> WR.
//  - mem_addr/mem_wdata/mem_write stay stable while mem_req = 1 and the request is unaccepted.
//    mem_req drops the cycle after an accept unless the next request follows immediately.
//    Back-to-back WR requests are allowed.
//  - start while busy is ignored. stop is sampled only in NEXT, so a pass is never truncated.
//  - Latency per read address: accept + controller read latency + 2 cycles (capture, CHK).
//  - Pattern P(p, a), with a zero-extended or truncated to DATA_BITS:
//    - p0 = a
//    - p1 = ~a
//    - p2 = a[0] ? {DATA_BITS/2{2'b10}} : {DATA_BITS/2{2'b01}}   (0x5555/0xAAAA at 16 bits)
//    - p3 = ~p2
//  - The last-address test is addr == {ADDR_BITS{1'b1}}; addr never wraps within a pass.
// CONFIGURATION
//  SRAM_SEQ_LFSR_EN defined:
//  - p3 = Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, replicated or truncated to DATA_BITS.
//  - Seeded to 16'hACE1 on entering the WR pass and again on entering the RD pass.
//  - Advances once per accepted write and once per captured read, so read expectations
//    reproduce the write sequence exactly.
//  SRAM_SEQ_LFSR_EN undefined: p3 = ~p2; no LFSR logic is synthesized.
// TESTING
//  1. ADDR_BITS=4, ideal SRAM model (mem_ready = 1, rvalid 1 cycle later), start, loop = 0
//     -> 4 passes of 16 writes + 16 chk_enable each; checker test_pass = 1; done = 1; iteration = 0.
//  2. mem_ready held low 5 cycles on write to addr 3
//     -> mem_addr = 3 and mem_wdata stay stable throughout; no address skipped; 16 writes total.
//  3. Model corrupts the read at addr 7, pattern 1 (returns 16'h0000)
//     -> chk_read_data = 0 and chk_expected_data = 16'hFFF8 on that strobe; checker latches the pair.
//  4. loop = 1 for 2 full loops, then assert stop during pattern 2
//     -> iteration = 2; pattern 2 completes; DONE entered with pattern = 2.
//  5. reset_n low for 1 cycle in RD_WAIT, spurious mem_rvalid the next cycle
//     -> all outputs 0, state IDLE, no chk_enable.
//  6. With SRAM_SEQ_LFSR_EN defined
//     -> pattern 3 first write data = 16'hACE1; the read pass expects the identical sequence.
//     Without the macro, the same run writes 16'hAAAA at addr 0.

Source files
------------

// File: rtl/sram_test_sequencer.sv
// Write-all / read-all SRAM test sequencer: one data pattern per pass, read words paired with
// expected values for the result checker. Optional LFSR pattern 3 with macro SRAM_SEQ_LFSR_EN.
module sram_test_sequencer #(
  parameter int ADDR_BITS = 20,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 loop,
  input  logic                 stop,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic                 mem_ready,
  input  logic                 mem_rvalid,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 chk_enable,
  output logic [DATA_BITS-1:0] chk_read_data,
  output logic [DATA_BITS-1:0] chk_expected_data,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           pattern,
  output logic [15:0]          iteration
);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, CHK, NEXT, DONE} state_e;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [1:0]             pattern_q, pattern_d;
  logic [15:0]            iteration_q, iteration_d;
  logic [DATA_BITS-1:0]   rdata_q, rdata_d;
  logic [DATA_BITS-1:0]   expected_q, expected_d;
  logic [DATA_BITS-1:0]   pat_word;
  logic                   last_addr;

`ifdef SRAM_SEQ_LFSR_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0]            lfsr_q, lfsr_d, lfsr_step;
  logic [DATA_BITS-1:0]   lfsr_word;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    lfsr_word = '0;
    for (int i = 0; i < DATA_BITS; i++) lfsr_word[i] = lfsr_q[i % 16];
  end
`endif

  assign last_addr = (addr_q == LAST_ADDR);

  // Data for the current (pattern, address); used both as write data and as read expectation.
  always_comb begin
    logic [DATA_BITS-1:0] a_ext;
    logic [DATA_BITS-1:0] alt;
    a_ext = DATA_BITS'(addr_q);
    alt   = addr_q[0] ? {(DATA_BITS/2){2'b10}} : {(DATA_BITS/2){2'b01}};
    unique case (pattern_q)
      2'd0:    pat_word = a_ext;
      2'd1:    pat_word = ~a_ext;
      2'd2:    pat_word = alt;
`ifdef SRAM_SEQ_LFSR_EN
      default: pat_word = lfsr_word;
`else
      default: pat_word = ~alt;
`endif
    endcase
  end

  // NOTE: every *_d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pattern_d   = pattern_q;
    iteration_d = iteration_q;
    rdata_d     = rdata_q;
    expected_d  = expected_q;
`ifdef SRAM_SEQ_LFSR_EN
    lfsr_d      = lfsr_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = WR;
          addr_d      = '0;
          pattern_d   = 2'd0;
          iteration_d = 16'd0;
`ifdef SRAM_SEQ_LFSR_EN
          lfsr_d      = LFSR_SEED;
`endif
        end
      end
      WR: begin
        if (mem_ready) begin
`ifdef SRAM_SEQ_LFSR_EN
          lfsr_d = last_addr ? LFSR_SEED : lfsr_step;
`endif
          if (last_addr) begin
            state_d = RD;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      RD: begin
        if (mem_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          rdata_d    = mem_rdata;
          expected_d = pat_word;
          state_d    = CHK;
`ifdef SRAM_SEQ_LFSR_EN
          lfsr_d     = lfsr_step;
`endif
        end
      end
      CHK: begin
        if (last_addr) begin
          state_d = NEXT;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = RD;
        end
      end
      NEXT: begin
        if (stop || (pattern_q == 2'd3 && !loop)) begin
          state_d = DONE;
        end else begin
          pattern_d = pattern_q + 2'd1;
          if (pattern_q == 2'd3) iteration_d = iteration_q + 16'd1;
          addr_d  = '0;
          state_d = WR;
`ifdef SRAM_SEQ_LFSR_EN
          lfsr_d  = LFSR_SEED;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      pattern_q   <= 2'd0;
      iteration_q <= 16'd0;
      rdata_q     <= '0;
      expected_q  <= '0;
`ifdef SRAM_SEQ_LFSR_EN
      lfsr_q      <= LFSR_SEED;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pattern_q   <= pattern_d;
      iteration_q <= iteration_d;
      rdata_q     <= rdata_d;
      expected_q  <= expected_d;
`ifdef SRAM_SEQ_LFSR_EN
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  // Request signals derive from registered state, so they stay stable until accepted.
  assign mem_req           = (state_q == WR) || (state_q == RD);
  assign mem_write         = (state_q == WR);
  assign mem_addr          = addr_q;
  assign mem_wdata         = (state_q == WR) ? pat_word : '0;
  assign chk_enable        = (state_q == CHK);
  assign chk_read_data     = rdata_q;
  assign chk_expected_data = expected_q;
  assign busy              = (state_q != IDLE) && (state_q != DONE);
  assign done              = (state_q == DONE);
  assign pattern           = pattern_q;
  assign iteration         = iteration_q;

endmodule
